gyro_scatter_engine: RTL and testbench
======================================

# gyro_scatter_engine

Parametrised charge-deposition engine for the particle loop. It accepts gyrocenter, gyroradius and charge per particle, and generates 1 point (drift-kinetic) or 4 points (gyro-averaged) per particle. Each point is deposited into a banked charge grid with bilinear weights and read-modify-write forwarding. It tracks in-flight work to signal scatter completion, then serves grid readback with optional clear-on-read for the solver.

## Interface
Parameters:
- GRID_LOG2, 4, log2 of grid edge; grid is 2^GRID_LOG2 × 2^GRID_LOG2.
- PFRAC, 4, fractional bits of position/radius.
- CWIDTH, 16, unsigned charge width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  particle valid.
- in_ready  out  1  particle accepted when in_valid && in_ready.
- in_last  in  1  marks final particle of the scatter phase.
- in_gx, in_gy  in  GRID_LOG2+PFRAC  gyrocenter, unsigned fixed point.
- in_rho  in  GRID_LOG2+PFRAC  gyroradius.
- in_q  in  CWIDTH  particle charge.
- gyro_en  in  1  sampled with each particle; 1 selects 4 gyropoints, 0 selects the gyrocenter only.
- done  out  1  one-cycle pulse when the last particle's final write has committed.
- rd_valid  in  1  solve-phase read request.
- rd_x, rd_y  in  GRID_LOG2  grid point to read.
- rd_clear  in  1  write zero to the point after reading it.
- solve_end  in  1  return to IDLE.
- out_valid  out  1  readback valid.
- out_charge  out  CWIDTH  readback value.

## Operation
- States: INIT → IDLE → SCATTER → DRAIN → SOLVE → IDLE.
- INIT, entered from reset: zeros every grid word, one address per bank per cycle, over 2^(2·GRID_LOG2)/4 cycles. in_ready=0 throughout.
- IDLE/SCATTER: the first accepted particle moves IDLE→SCATTER. Accepting a particle with in_last moves to DRAIN.
- Gyropoints, with gyro_en=1 and index k=0..3:
  - k=0: (gx−rho, gy).
  - k=1: (gx+rho, gy).
  - k=2: (gx, gy−rho).
  - k=3: (gx, gy+rho).
  - Addition is modulo the grid size (periodic wrap).
- Per-point charge: q_pt = in_q>>2 when gyro_en=1, else in_q (truncating).
- Bilinear weights from fractions fx, fy (PFRAC bits each):
  - (i, j): (1−fx)(1−fy).
  - (i+1, j): fx(1−fy).
  - (i, j+1): (1−fx)fy.
  - (i+1, j+1): fx·fy.
  - Deposit = (q_pt·w)>>(2·PFRAC), truncating. Neighbour indices wrap.
- Banks: 4, selected by {y[0], x[0]}, each of depth 2^(2·GRID_LOG2)/4. The four corners of any cell always land in distinct banks, so each bank does one RMW per cycle.
- Accumulation saturates at 2^CWIDTH−1.
- RMW hazard: a write to an address still in the read→write window must be forwarded into the following update. No deposit may be lost.
- DRAIN: waits until the in-flight counter reaches 0, pulses done, then enters SOLVE.
- SOLVE: in_ready=0. rd_valid is accepted every cycle. With rd_clear, the word becomes 0 after it is read. solve_end → IDLE. rd_valid is ignored outside SOLVE.

## Timing
- Reset values: in_ready=0, done=0, out_valid=0, out_charge=0.
- in_ready rises on the cycle after INIT completes.
- Throughput:
  - gyro_en=1: one gyropoint per cycle, so in_ready drops for 3 cycles after each acceptance.
  - gyro_en=0: one particle per cycle.
- Pipeline, counting from acceptance edge T:
  - T+1: gyropoint registered.
  - T+2: weights and bank read address issued.
  - T+3: read data returns and the add is performed.
  - T+4: write commits.
- done is asserted in the cycle after the final commit.
- Readback: out_valid and out_charge appear 2 cycles after rd_valid is sampled. A clear takes effect before any later read.
- rst mid-operation: drops all in-flight work and re-enters INIT.

## Structure
- Add to package defs: GRID_LOG2, PFRAC, CWIDTH defaults; gyro_pt_t {y, x}; the scatter_state_t enum.
- One sub-module, deposit_bank: a single parity bank with registered read, saturating add, 2-deep address/data forwarding, a clear port and an INIT-sweep port. It is instantiated 4×.

## Test plan
All scenarios use defaults (16×16 grid, PFRAC=4).
- Reset: in_ready stays 0 for 64 cycles, then 1. Reading all 256 points returns 0.
- Single point: gyro_en=0, gx=0x30, gy=0x50, q=1024, in_last=1 → (3,5)=1024, its neighbours 0. done pulses at T+5.
- Bilinear split: gyro_en=0, gx=0x38, gy=0x58, q=1024 → (3,5), (4,5), (3,6), (4,6) each read 256.
- Gyro-average: gyro_en=1, gx=gy=0x80, rho=0x20, q=1024 → (6,8), (10,8), (8,6), (8,10) each read 256. in_ready is low for 3 cycles.
- Wrap: gyro_en=0, gx=0xF8, gy=0x00, q=512 → (15,0)=256 and (0,0)=256.
- Hazard and clear: 8 back-to-back particles at gx=gy=0x20, q=100, with in_last on the 8th → (2,2)=800. done fires exactly once. Reading with rd_clear returns 800; a re-read returns 0.

Source files
------------

// File: rtl/gyro_scatter_engine_pkg.sv
// gyro_scatter_engine_pkg: default sizes, gyropoint type and controller states
package gyro_scatter_engine_pkg;
    localparam int GRID_LOG2_DEF = 4;
    localparam int PFRAC_DEF = 4;
    localparam int CWIDTH_DEF = 16;
    localparam int PT_W = GRID_LOG2_DEF + PFRAC_DEF;
    typedef struct packed {
        logic [PT_W-1:0] y;
        logic [PT_W-1:0] x;
    } gyro_pt_t;
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCATTER, S_DRAIN, S_SOLVE} scatter_state_t;
endpackage

// File: rtl/gyro_scatter_engine_deposit_bank.sv
// gyro_scatter_engine_deposit_bank: one parity bank with registered read, saturating RMW, forwarding, clear and init sweep
module gyro_scatter_engine_deposit_bank #(
    parameter int ABITS = 6,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_v,
    input  logic [ABITS-1:0]  init_addr,
    input  logic              req_v,
    input  logic [ABITS-1:0]  req_addr,
    input  logic [CWIDTH-1:0] req_dep,
    input  logic              req_clr,
    output logic [CWIDTH-1:0] rdata
);
    logic [CWIDTH-1:0] mem [2**ABITS];
    logic v_q, v_d, w1v_q, w1v_d, w2v_q, w2v_d;
    logic [ABITS-1:0] a_q, a_d, w1a_q, w1a_d, w2a_q, w2a_d;
    logic [CWIDTH-1:0] d_q, d_d, rd_q, rd_d, w1d_q, w1d_d, w2d_q, w2d_d, base, sum;
    logic [CWIDTH:0] raw;
    always_comb begin
        base = (w1v_q && w1a_q == a_q) ? w1d_q : (w2v_q && w2a_q == a_q) ? w2d_q : rd_q;
        raw = {1'b0, base} + {1'b0, d_q};
        sum = raw[CWIDTH] ? '1 : raw[CWIDTH-1:0];
        v_d = req_v;
        a_d = req_addr;
        d_d = req_dep;
        rd_d = mem[req_addr];
        w1v_d = v_q;
        w1a_d = a_q;
        w1d_d = sum;
        w2v_d = w1v_q;
        w2a_d = w1a_q;
        w2d_d = w1d_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            w1v_q <= 1'b0;
            w2v_q <= 1'b0;
        end else begin
            v_q <= v_d;
            w1v_q <= w1v_d;
            w2v_q <= w2v_d;
        end
        a_q <= a_d;
        d_q <= d_d;
        rd_q <= rd_d;
        w1a_q <= w1a_d;
        w1d_q <= w1d_d;
        w2a_q <= w2a_d;
        w2d_q <= w2d_d;
        if (init_v) mem[init_addr] <= '0;
        else if (req_clr) mem[req_addr] <= '0;
        else if (v_q && !rst) mem[a_q] <= sum;
    end
    assign rdata = rd_q;
endmodule

// File: rtl/gyro_scatter_engine.sv
// gyro_scatter_engine: gyro-averaged bilinear charge deposition into four parity banks with solver readback
module gyro_scatter_engine
    import gyro_scatter_engine_pkg::*;
#(
    parameter int GRID_LOG2 = GRID_LOG2_DEF,
    parameter int PFRAC = PFRAC_DEF,
    parameter int CWIDTH = CWIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [GRID_LOG2+PFRAC-1:0] in_gx,
    input  logic [GRID_LOG2+PFRAC-1:0] in_gy,
    input  logic [GRID_LOG2+PFRAC-1:0] in_rho,
    input  logic [CWIDTH-1:0]          in_q,
    input  logic                       gyro_en,
    output logic                       done,
    input  logic                       rd_valid,
    input  logic [GRID_LOG2-1:0]       rd_x,
    input  logic [GRID_LOG2-1:0]       rd_y,
    input  logic                       rd_clear,
    input  logic                       solve_end,
    output logic                       out_valid,
    output logic [CWIDTH-1:0]          out_charge
);
    localparam int PW = GRID_LOG2 + PFRAC;
    localparam int ABITS = 2 * GRID_LOG2 - 2;
    localparam int MW = CWIDTH + 2 * PFRAC + 2;
    localparam int ONE = 2 ** PFRAC;

    scatter_state_t state_q, state_d;
    logic [ABITS-1:0] init_cnt_q, init_cnt_d;
    logic [1:0] k_q, k_d, rdb1_q, rdb1_d, rdb2_q, rdb2_d;
    logic [PW-1:0] gx_q, gx_d, gy_q, gy_d, rho_q, rho_d;
    logic [CWIDTH-1:0] qp_q, qp_d, out_charge_q, out_charge_d;
    gyro_pt_t pt_q, pt_d;
    logic pt_v_q, pt_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d, done_q, done_d;
    logic rdv1_q, rdv1_d, rdv2_q, rdv2_d, out_valid_q, out_valid_d, accept, rd_acc;
    logic [3:0] cnt_q, cnt_d, s2_clr_q, s2_clr_d;
    logic [ABITS-1:0] s2_addr_q [4], s2_addr_d [4];
    logic [CWIDTH-1:0] s2_dep_q [4], s2_dep_d [4], rdata [4];
    logic [GRID_LOG2-1:0] ix, iy;
    logic [GRID_LOG2-2:0] cx, cy;
    logic [PFRAC-1:0] fx, fy;
    logic [PFRAC:0] wx, wy;
    logic [MW-1:0] prod;

    function automatic gyro_pt_t gyro_point(input logic [1:0] k, input logic [PW-1:0] gx, gy, rho);
        gyro_point.x = k == 2'd0 ? gx - rho : k == 2'd1 ? gx + rho : gx;
        gyro_point.y = k == 2'd2 ? gy - rho : k == 2'd3 ? gy + rho : gy;
    endfunction

    assign in_ready = (state_q == S_IDLE || state_q == S_SCATTER) && k_q == 2'd0;

    always_comb begin
        accept = in_valid && in_ready;
        rd_acc = rd_valid && state_q == S_SOLVE;
        state_d = state_q;
        if (state_q == S_INIT && &init_cnt_q) state_d = S_IDLE;
        if (accept) state_d = in_last ? S_DRAIN : S_SCATTER;
        if (state_q == S_DRAIN && cnt_q == '0) state_d = S_SOLVE;
        if (state_q == S_SOLVE && solve_end) state_d = S_IDLE;
        done_d = state_q == S_DRAIN && cnt_q == '0;
        init_cnt_d = state_q == S_INIT ? init_cnt_q + 1'b1 : '0;
        k_d = (accept && gyro_en) ? 2'd1 : (k_q == 2'd0 || k_q == 2'd3) ? 2'd0 : k_q + 2'd1;
        gx_d = accept ? in_gx : gx_q;
        gy_d = accept ? in_gy : gy_q;
        rho_d = accept ? in_rho : rho_q;
        qp_d = accept ? (gyro_en ? in_q >> 2 : in_q) : qp_q;
        pt_v_d = accept || k_q != 2'd0;
        pt_d = accept ? gyro_point(2'd0, in_gx, in_gy, gyro_en ? in_rho : '0) : gyro_point(k_q, gx_q, gy_q, rho_q);
        s2_v_d = pt_v_q;
        s3_v_d = s2_v_q;
        cnt_d = cnt_q + 4'(pt_v_d) - 4'(s3_v_q);
        ix = pt_q.x[PW-1:PFRAC];
        iy = pt_q.y[PW-1:PFRAC];
        fx = pt_q.x[PFRAC-1:0];
        fy = pt_q.y[PFRAC-1:0];
        cx = '0;
        cy = '0;
        wx = '0;
        wy = '0;
        prod = '0;
        // each bank owns exactly one cell corner, chosen by matching its parity to the base index
        for (int b = 0; b < 4; b++) begin
            cx = (b[0] == ix[0]) ? ix[GRID_LOG2-1:1] : ix[GRID_LOG2-1:1] + (GRID_LOG2-1)'(ix[0]);
            cy = (b[1] == iy[0]) ? iy[GRID_LOG2-1:1] : iy[GRID_LOG2-1:1] + (GRID_LOG2-1)'(iy[0]);
            wx = (b[0] == ix[0]) ? (PFRAC+1)'(ONE - int'(fx)) : (PFRAC+1)'(fx);
            wy = (b[1] == iy[0]) ? (PFRAC+1)'(ONE - int'(fy)) : (PFRAC+1)'(fy);
            prod = MW'(qp_q) * MW'(wx) * MW'(wy);
            s2_dep_d[b] = CWIDTH'(prod >> (2 * PFRAC));
            s2_addr_d[b] = state_q == S_SOLVE ? {rd_y[GRID_LOG2-1:1], rd_x[GRID_LOG2-1:1]} : {cy, cx};
            s2_clr_d[b] = rd_acc && rd_clear && 2'(b) == {rd_y[0], rd_x[0]};
        end
        rdv1_d = rd_acc;
        rdb1_d = {rd_y[0], rd_x[0]};
        rdv2_d = rdv1_q;
        rdb2_d = rdb1_q;
        out_valid_d = rdv2_q;
        out_charge_d = rdv2_q ? rdata[rdb2_q] : out_charge_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            init_cnt_q <= '0;
            k_q <= '0;
            pt_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            cnt_q <= '0;
            s2_clr_q <= '0;
            rdv1_q <= 1'b0;
            rdv2_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_charge_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            init_cnt_q <= init_cnt_d;
            k_q <= k_d;
            pt_v_q <= pt_v_d;
            s2_v_q <= s2_v_d;
            s3_v_q <= s3_v_d;
            cnt_q <= cnt_d;
            s2_clr_q <= s2_clr_d;
            rdv1_q <= rdv1_d;
            rdv2_q <= rdv2_d;
            out_valid_q <= out_valid_d;
            out_charge_q <= out_charge_d;
            done_q <= done_d;
        end
        gx_q <= gx_d;
        gy_q <= gy_d;
        rho_q <= rho_d;
        qp_q <= qp_d;
        pt_q <= pt_d;
        s2_addr_q <= s2_addr_d;
        s2_dep_q <= s2_dep_d;
        rdb1_q <= rdb1_d;
        rdb2_q <= rdb2_d;
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        gyro_scatter_engine_deposit_bank #(.ABITS(ABITS), .CWIDTH(CWIDTH)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .init_v   (state_q == S_INIT),
            .init_addr(init_cnt_q),
            .req_v    (s2_v_q),
            .req_addr (s2_addr_q[g]),
            .req_dep  (s2_dep_q[g]),
            .req_clr  (s2_clr_q[g]),
            .rdata    (rdata[g])
        );
    end

    assign done = done_q;
    assign out_valid = out_valid_q;
    assign out_charge = out_charge_q;
endmodule

// File: tb/tb_gyro_scatter_engine.sv
// tb_gyro_scatter_engine: directed scatter/readback scenarios checked against a grid model through a readback scoreboard
module tb_gyro_scatter_engine;
    logic clk, rst, in_valid, in_ready, in_last, gyro_en, done;
    logic rd_valid, rd_clear, solve_end, out_valid;
    logic [7:0] in_gx, in_gy, in_rho;
    logic [15:0] in_q, out_charge;
    logic [3:0] rd_x, rd_y;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int grid [16][16];
    int exp_q [$];
    int tag_q [$];

    gyro_scatter_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_gx(in_gx), .in_gy(in_gy), .in_rho(in_rho), .in_q(in_q), .gyro_en(gyro_en),
        .done(done), .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_clear(rd_clear),
        .solve_end(solve_end), .out_valid(out_valid), .out_charge(out_charge)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (done) done_cnt++;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", {31'b0, out_valid}, 0);
            else begin
                int e, t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check($sformatf("rd(%0d,%0d)", t / 16, t % 16), {16'b0, out_charge}, e);
            end
        end
    end

    task automatic add(input int x, input int y, input int v);
        int s;
        s = grid[x & 15][y & 15] + v;
        grid[x & 15][y & 15] = s > 65535 ? 65535 : s;
    endtask

    task automatic model_point(input int x, input int y, input int q);
        int ix, iy, fx, fy;
        ix = x >> 4; iy = y >> 4; fx = x & 15; fy = y & 15;
        add(ix, iy, (q * (16 - fx) * (16 - fy)) >> 8);
        add(ix + 1, iy, (q * fx * (16 - fy)) >> 8);
        add(ix, iy + 1, (q * (16 - fx) * fy) >> 8);
        add(ix + 1, iy + 1, (q * fx * fy) >> 8);
    endtask

    task automatic send(input int gx, input int gy, input int rho, input int q, input bit gen, input bit last);
        int w = 0;
        in_valid = 1; in_gx = 8'(gx); in_gy = 8'(gy); in_rho = 8'(rho); in_q = 16'(q);
        gyro_en = gen; in_last = last;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (w == 50) check("in_ready_timeout", {31'b0, in_ready}, 1);
        if (gen) begin
            model_point((gx - rho) & 255, gy, q >> 2);
            model_point((gx + rho) & 255, gy, q >> 2);
            model_point(gx, (gy - rho) & 255, q >> 2);
            model_point(gx, (gy + rho) & 255, q >> 2);
        end else model_point(gx, gy, q);
        @(negedge clk);
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("done_seen", {31'b0, done}, 1);
    endtask

    task automatic rd(input int x, input int y, input bit clr);
        rd_valid = 1; rd_x = 4'(x); rd_y = 4'(y); rd_clear = clr;
        exp_q.push_back(grid[x][y]);
        tag_q.push_back(x * 16 + y);
        if (clr) grid[x][y] = 0;
        @(negedge clk);
        rd_valid = 0; rd_clear = 0;
    endtask

    task automatic drain_reads();
        int w = 0;
        while (exp_q.size() > 0 && w < 20) begin @(negedge clk); w++; end
        check("readback_drained", exp_q.size(), 0);
    endtask

    task automatic read_all();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) rd(x, y, 1);
        drain_reads();
    endtask

    task automatic end_solve();
        solve_end = 1;
        @(negedge clk);
        solve_end = 0;
        check("idle_ready", {31'b0, in_ready}, 1);
    endtask

    task automatic do_init();
        int lows = 0;
        rst = 0;
        for (int i = 0; i < 64; i++) begin
            lows += in_ready ? 0 : 1;
            @(negedge clk);
        end
        check("init_ready_low_cycles", lows, 64);
        check("ready_after_init", {31'b0, in_ready}, 1);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) grid[x][y] = 0;
    endtask

    initial begin
        int lat, lows, d0;
        rst = 1; in_valid = 0; in_last = 0; gyro_en = 0; in_gx = 0; in_gy = 0; in_rho = 0; in_q = 0;
        rd_valid = 0; rd_x = 0; rd_y = 0; rd_clear = 0; solve_end = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_charge", {16'b0, out_charge}, 0);
        do_init();

        send(8'h30, 8'h50, 0, 1024, 0, 1);
        wait_done(lat);
        check("done_latency_single", lat, 5);
        read_all();
        end_solve();

        send(8'h38, 8'h58, 0, 1024, 0, 1);
        wait_done(lat);
        read_all();
        end_solve();

        send(8'h80, 8'h80, 8'h20, 1024, 1, 0);
        lows = 0;
        while (!in_ready && lows < 10) begin lows++; @(negedge clk); end
        check("gyro_ready_low_cycles", lows, 3);
        send(0, 0, 0, 0, 0, 1);
        wait_done(lat);
        read_all();
        end_solve();

        send(8'hF8, 8'h00, 0, 512, 0, 1);
        wait_done(lat);
        read_all();
        end_solve();

        send(8'h40, 8'h40, 0, 65535, 0, 0);
        send(8'h40, 8'h40, 0, 65535, 0, 1);
        wait_done(lat);
        read_all();
        end_solve();

        d0 = done_cnt;
        for (int i = 0; i < 8; i++) send(8'h20, 8'h20, 0, 100, 0, i == 7);
        wait_done(lat);
        repeat (4) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        rd(2, 2, 1);
        rd(2, 2, 0);
        read_all();
        end_solve();

        rd_valid = 1; rd_x = 4'd2; rd_y = 4'd2;
        repeat (2) @(negedge clk);
        rd_valid = 0;
        repeat (4) @(negedge clk);

        d0 = done_cnt;
        send(8'h30, 8'h30, 0, 500, 0, 1);
        rst = 1;
        @(negedge clk);
        do_init();
        repeat (8) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
